// File: rtl/can_pkg.sv
// can_pkg: shared CAN 2.0A widths, stuffing limit and arbitration-receiver state type
package can_pkg;
  localparam int ID_W        = 11;
  localparam int STUFF_LIMIT = 5;
  typedef enum logic [2:0] {IDLE, RECV_ID, RECV_RTR, COMPLETE, ERROR} arb_rx_state_t;
endpackage

// File: rtl/arb_field_rx_if.sv
// arb_field_rx_if: bit-timing inputs and decoded arbitration-field outputs
//   master: bit-timing side, drives enable/sample_point/rx_bit/sof_detected
//   slave : arb_field_rx, drives id_out/rtr_rx/remote_frame/arb_complete/stuff_error/busy
interface arb_field_rx_if;
  import can_pkg::*;
  logic            enable;
  logic            sample_point;
  logic            rx_bit;
  logic            sof_detected;
  logic [ID_W-1:0] id_out;
  logic            rtr_rx;
  logic            remote_frame;
  logic            arb_complete;
  logic            stuff_error;
  logic            busy;
  modport master (
    output enable, sample_point, rx_bit, sof_detected,
    input  id_out, rtr_rx, remote_frame, arb_complete, stuff_error, busy
  );
  modport slave (
    input  enable, sample_point, rx_bit, sof_detected,
    output id_out, rtr_rx, remote_frame, arb_complete, stuff_error, busy
  );
endinterface

// File: rtl/bit_destuffer.sv
// bit_destuffer: CAN bit de-stuffing, classifies each sampled bit as data, stuff or stuff violation
//   in : clock, reset_n, clr (drop run count), sof (restart run with SOF), bit_evt, rx_bit
//   out: data_valid/data_bit (combinational, this sample), stuff_err (combinational, this sample)
module bit_destuffer
  import can_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic sof,
  input  logic bit_evt,
  input  logic rx_bit,
  output logic data_valid,
  output logic data_bit,
  output logic stuff_err
);
  logic [2:0] run_len_q, run_len_d;
  logic       last_bit_q, last_bit_d;
  logic       stuff_slot;
  always_comb begin
    stuff_slot = run_len_q == 3'(STUFF_LIMIT);
    data_valid = bit_evt && !stuff_slot;
    data_bit   = rx_bit;
    stuff_err  = bit_evt && stuff_slot && rx_bit == last_bit_q;
    // SOF is a dominant bit and already counts as the first of a run
    run_len_d  = clr ? 3'd0 : sof ? 3'd1 : !bit_evt ? run_len_q :
                 (stuff_slot || rx_bit != last_bit_q) ? 3'd1 : run_len_q + 3'd1;
    last_bit_d = clr ? last_bit_q : sof ? 1'b0 : bit_evt ? rx_bit : last_bit_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      run_len_q  <= '0;
      last_bit_q <= 1'b0;
    end else begin
      run_len_q  <= run_len_d;
      last_bit_q <= last_bit_d;
    end
endmodule

// File: rtl/arb_field_rx.sv
// arb_field_rx: CAN arbitration-field receiver (11-bit ID + RTR) with de-stuffing
//   clock, reset_n (async, active-low)
//   bus (slave): enable, sample_point, rx_bit, sof_detected in;
//                id_out, rtr_rx, remote_frame, arb_complete, stuff_error, busy out (all registered)
module arb_field_rx
  import can_pkg::*;
(
  input logic         clock,
  input logic         reset_n,
  arb_field_rx_if.slave bus
);
  arb_rx_state_t   state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [ID_W-1:0] id_out_q, id_out_d;
  logic            rtr_rx_q, rtr_rx_d;
  logic            remote_frame_q, remote_frame_d;
  logic            arb_complete_q, arb_complete_d;
  logic            stuff_error_q, stuff_error_d;
  logic            busy_q, busy_d;
  logic            sof, receiving, bit_evt, data_valid, data_bit, stuff_err, shift_id, take_rtr;
  assign sof       = bus.enable && bus.sof_detected;
  assign receiving = state_q inside {RECV_ID, RECV_RTR};
  // SOF wins over the bit sample it coincides with, so that sample never reaches the destuffer
  assign bit_evt   = bus.enable && bus.sample_point && receiving && !sof;
  bit_destuffer u_destuff (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr        (!bus.enable),
    .sof        (sof),
    .bit_evt    (bit_evt),
    .rx_bit     (bus.rx_bit),
    .data_valid (data_valid),
    .data_bit   (data_bit),
    .stuff_err  (stuff_err)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      id_out_q       <= '0;
      rtr_rx_q       <= 1'b0;
      remote_frame_q <= 1'b0;
      arb_complete_q <= 1'b0;
      stuff_error_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      id_out_q       <= id_out_d;
      rtr_rx_q       <= rtr_rx_d;
      remote_frame_q <= remote_frame_d;
      arb_complete_q <= arb_complete_d;
      stuff_error_q  <= stuff_error_d;
      busy_q         <= busy_d;
    end
  always_comb begin
    state_d = state_q;
    if (!bus.enable) state_d = IDLE;
    else if (sof) state_d = RECV_ID;
    else
      case (state_q)
        RECV_ID:         state_d = stuff_err ? ERROR : (data_valid && bit_cnt_q == 4'd10) ? RECV_RTR : RECV_ID;
        RECV_RTR:        state_d = stuff_err ? ERROR : data_valid ? COMPLETE : RECV_RTR;
        COMPLETE, ERROR: state_d = IDLE;
        default:         state_d = state_q;
      endcase
  end
  // Pulses and busy are registered from the next state so they line up with the state itself;
  // remote_frame is loaded together with rtr_rx so it is valid while arb_complete is high.
  always_comb begin
    shift_id       = data_valid && state_q == RECV_ID;
    take_rtr       = data_valid && state_q == RECV_RTR;
    bit_cnt_d      = (!bus.enable || sof) ? 4'd0 : shift_id ? bit_cnt_q + 4'd1 : bit_cnt_q;
    id_out_d       = sof ? '0 : shift_id ? {id_out_q[ID_W-2:0], data_bit} : id_out_q;
    rtr_rx_d       = sof ? 1'b0 : take_rtr ? data_bit : rtr_rx_q;
    remote_frame_d = sof ? 1'b0 : take_rtr ? data_bit : remote_frame_q;
    arb_complete_d = state_d == COMPLETE;
    stuff_error_d  = state_d == ERROR;
    busy_d         = state_d inside {RECV_ID, RECV_RTR};
  end
  assign bus.id_out       = id_out_q;
  assign bus.rtr_rx       = rtr_rx_q;
  assign bus.remote_frame = remote_frame_q;
  assign bus.arb_complete = arb_complete_q;
  assign bus.stuff_error  = stuff_error_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_arb_field_rx.sv
// tb_arb_field_rx: randomized self-checking bench for arb_field_rx against a bit-stuffing frame model
module tb_arb_field_rx;
  import can_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  arb_field_rx_if bus();
  arb_field_rx dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  int n_vec = 0, n_bad = 0, n_cmp = 0, n_err = 0;
  bit sq[$];
  bit fq[$];
  always @(negedge clock) begin
    if (bus.arb_complete === 1'b1) n_cmp++;
    if (bus.stuff_error === 1'b1) n_err++;
  end
  // Transmit-side view of a frame: SOF, ID MSB first, RTR, with a complementary stuff bit
  // inserted before any bit that follows five equal bits on the wire. fq marks stuff bits.
  task automatic build(input logic [10:0] id, input bit rtr);
    bit last, b;
    int run;
    sq.delete(); fq.delete();
    sq.push_back(1'b0); fq.push_back(1'b0);
    last = 1'b0; run = 1;
    for (int i = 0; i < 12; i++) begin
      b = (i < 11) ? id[10-i] : rtr;
      if (run == STUFF_LIMIT) begin
        sq.push_back(!last); fq.push_back(1'b1);
        last = !last; run = 1;
      end
      sq.push_back(b); fq.push_back(1'b0);
      if (b == last) run++;
      else begin last = b; run = 1; end
    end
  endtask
  function automatic int upto(input int n);
    int c = 0;
    for (int i = 0; i < sq.size(); i++) begin
      if (!fq[i]) c++;
      if (c == n) return i + 1;
    end
    return sq.size();
  endfunction
  task automatic drive_bit(input bit b, input bit s);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clock);
      bus.rx_bit = 1'($urandom);
    end
    @(negedge clock);
    bus.sample_point = 1'b1; bus.rx_bit = b; bus.sof_detected = s;
    @(posedge clock); #1;
    bus.sample_point = 1'b0; bus.sof_detected = 1'b0;
  endtask
  task automatic drive_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) drive_bit(sq[i], i == 0);
  endtask
  task automatic test_frame(input string nm, input logic [10:0] id, input bit rtr);
    int c0, e0;
    c0 = n_cmp; e0 = n_err;
    build(id, rtr);
    drive_range(0, sq.size());
    n_vec++; if (bus.arb_complete !== 1'b1) begin n_bad++; $display("FAIL %s_latency: arb_complete=%b want 1", nm, bus.arb_complete); end
    repeat (3) @(posedge clock); #1;
    n_vec++; if (bus.id_out !== id) begin n_bad++; $display("FAIL %s_id: got %h want %h", nm, bus.id_out, id); end
    n_vec++; if (bus.rtr_rx !== rtr) begin n_bad++; $display("FAIL %s_rtr: got %b want %b", nm, bus.rtr_rx, rtr); end
    n_vec++; if (bus.remote_frame !== rtr) begin n_bad++; $display("FAIL %s_remote: got %b want %b", nm, bus.remote_frame, rtr); end
    n_vec++; if (n_cmp - c0 !== 1) begin n_bad++; $display("FAIL %s_cmp_pulses: got %0d want 1", nm, n_cmp - c0); end
    n_vec++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL %s_err_pulses: got %0d want 0", nm, n_err - e0); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b want 0", nm, bus.busy); end
  endtask
  task automatic test_reset();
    bus.enable = 1'b1; bus.sample_point = 1'b0; bus.rx_bit = 1'b1; bus.sof_detected = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock); #1;
    n_vec++; if (bus.id_out !== 11'h000) begin n_bad++; $display("FAIL reset_id: got %h want 000", bus.id_out); end
    n_vec++; if (bus.rtr_rx !== 1'b0) begin n_bad++; $display("FAIL reset_rtr: got %b want 0", bus.rtr_rx); end
    n_vec++; if (bus.remote_frame !== 1'b0) begin n_bad++; $display("FAIL reset_remote: got %b want 0", bus.remote_frame); end
    n_vec++; if (bus.arb_complete !== 1'b0) begin n_bad++; $display("FAIL reset_cmp: got %b want 0", bus.arb_complete); end
    n_vec++; if (bus.stuff_error !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.stuff_error); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(posedge clock); #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
  endtask
  task automatic test_basic();
    test_frame("basic", 11'h123, 1'b0);
  endtask
  task automatic test_stuffed();
    test_frame("stuffed", 11'h000, 1'b1);
  endtask
  task automatic test_stuff_error();
    int j, c0, e0;
    c0 = n_cmp; e0 = n_err;
    build(11'h000, 1'b1);
    j = 0;
    while (!fq[j]) j++;
    sq[j] = 1'b0;
    drive_range(0, j);
    drive_bit(sq[j], 1'b0);
    n_vec++; if (bus.stuff_error !== 1'b1) begin n_bad++; $display("FAIL stufferr_pulse: got %b want 1", bus.stuff_error); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stufferr_busy: got %b want 0", bus.busy); end
    @(posedge clock); #1;
    n_vec++; if (bus.stuff_error !== 1'b0) begin n_bad++; $display("FAIL stufferr_width: got %b want 0", bus.stuff_error); end
    drive_range(j + 1, sq.size());
    repeat (3) @(posedge clock); #1;
    n_vec++; if (n_cmp - c0 !== 0) begin n_bad++; $display("FAIL stufferr_cmp: got %0d want 0", n_cmp - c0); end
    n_vec++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL stufferr_count: got %0d want 1", n_err - e0); end
    n_vec++; if (bus.id_out !== 11'h000) begin n_bad++; $display("FAIL stufferr_id: got %h want 000", bus.id_out); end
  endtask
  task automatic test_enable_drop();
    int c0, e0;
    c0 = n_cmp; e0 = n_err;
    build(11'h7FF, 1'b0);
    drive_range(0, upto(7));
    n_vec++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL endrop_busy_pre: got %b want 1", bus.busy); end
    @(negedge clock); bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom), 1'b0);
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL endrop_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.id_out !== 11'h03F) begin n_bad++; $display("FAIL endrop_id_hold: got %h want 03f", bus.id_out); end
    n_vec++; if (n_cmp - c0 !== 0 || n_err - e0 !== 0) begin n_bad++; $display("FAIL endrop_pulses: got cmp=%0d err=%0d want 0/0", n_cmp - c0, n_err - e0); end
    @(negedge clock); bus.enable = 1'b1;
    test_frame("endrop_resume", 11'h7FF, 1'b0);
  endtask
  task automatic test_async_reset();
    int k, c0, e0;
    logic [10:0] id;
    id = 11'($urandom_range(1024, 2047));
    build(id, 1'($urandom));
    k = upto(9);
    drive_range(0, k);
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (bus.id_out !== 11'h000) begin n_bad++; $display("FAIL areset_id: got %h want 000", bus.id_out); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b want 0", bus.busy); end
    n_vec++; if ({bus.rtr_rx, bus.remote_frame, bus.arb_complete, bus.stuff_error} !== 4'b0000) begin n_bad++; $display("FAIL areset_flags: got %b want 0000", {bus.rtr_rx, bus.remote_frame, bus.arb_complete, bus.stuff_error}); end
    @(negedge clock); reset_n = 1'b1;
    c0 = n_cmp; e0 = n_err;
    drive_range(k, sq.size());
    repeat (3) @(posedge clock); #1;
    n_vec++; if (n_cmp - c0 !== 0 || n_err - e0 !== 0) begin n_bad++; $display("FAIL areset_pulses: got cmp=%0d err=%0d want 0/0", n_cmp - c0, n_err - e0); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL areset_idle: got %b want 0", bus.busy); end
  endtask
  task automatic test_restart();
    build(11'h555, 1'b0);
    drive_range(0, upto(6));
    n_vec++; if (bus.id_out !== 11'h015) begin n_bad++; $display("FAIL restart_partial: got %h want 015", bus.id_out); end
    test_frame("restart", 11'h2AA, 1'b1);
  endtask
  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      logic [10:0] id, exp_id;
      bit rtr;
      int st[$];
      int j, cnt, c0, e0;
      id = 11'($urandom_range(0, 2047));
      rtr = 1'($urandom);
      build(id, rtr);
      st.delete();
      for (int i = 1; i < sq.size(); i++) if (fq[i]) st.push_back(i);
      if (st.size() == 0 || $urandom_range(0, 2) != 0) test_frame("random", id, rtr);
      else begin
        j = st[$urandom_range(0, st.size() - 1)];
        sq[j] = sq[j-1];
        exp_id = '0; cnt = 0;
        for (int i = 1; i < j; i++)
          if (!fq[i] && cnt < 11) begin exp_id = {exp_id[9:0], sq[i]}; cnt++; end
        c0 = n_cmp; e0 = n_err;
        drive_range(0, sq.size());
        repeat (3) @(posedge clock); #1;
        n_vec++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL rand_err_count: got %0d want 1", n_err - e0); end
        n_vec++; if (n_cmp - c0 !== 0) begin n_bad++; $display("FAIL rand_err_cmp: got %0d want 0", n_cmp - c0); end
        n_vec++; if (bus.id_out !== exp_id) begin n_bad++; $display("FAIL rand_err_id: got %h want %h", bus.id_out, exp_id); end
        n_vec++; if (bus.remote_frame !== 1'b0) begin n_bad++; $display("FAIL rand_err_remote: got %b want 0", bus.remote_frame); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stuffed();
    test_stuff_error();
    test_enable_drop();
    test_async_reset();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
